// File: rtl/lspc_pkg.sv
// Shared types and constants for the LSPC CPU-side VRAM sequencer.
package lspc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_ACC = 2'd1,
      ST_RD_ACC = 2'd2,
      ST_RD_CAP = 2'd3
   } state_t;

   localparam logic [15:0] VRAM_RESET_ADDR = 16'h0000;

endpackage

// File: rtl/lspc_strobe_edge.sv
// Falling-edge detector for an active-low register strobe.
module lspc_strobe_edge
   import lspc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic fire
);

   logic prev;

   always_ff @(posedge clk) begin
      if (!reset) prev <= 1'b1;
      else        prev <= strobe;
   end

   assign fire = ~strobe & prev;

endmodule

// File: rtl/lspc_vram_access.sv
// CPU-side VRAM access sequencer: pointer, pending flags, slot-driven
// write/read FSM.
module lspc_vram_access
   import lspc_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          CLK_24M,
   input  logic          RESET,
   input  logic          WR_VRAM_ADDR,
   input  logic          WR_VRAM_RW,
   input  logic [15:0]   M68K_DATA,
   input  logic [15:0]   REG_VRAMMOD,
   input  logic          CPU_SLOT,
   input  logic [DW-1:0] VRAM_RDATA,
   output logic [AW-1:0] VRAM_ADDR,
   output logic [DW-1:0] VRAM_WDATA,
   output logic          nVRAM_WE,
   output logic          VRAM_CPU_SEL,
   output logic [AW-1:0] REG_VRAMADDR,
   output logic [DW-1:0] REG_VRAMRW,
   output logic          nVRAM_WRITE_REQ,
   output logic          BUSY
);

   state_t        state;
   logic          wr_pend;
   logic          rd_pend;
   logic          addr_fire;
   logic          data_fire;
   logic [DW-1:0] latch;

   lspc_strobe_edge u_addr_edge (
      .clk    (CLK_24M),
      .reset  (RESET),
      .strobe (WR_VRAM_ADDR),
      .fire   (addr_fire)
   );

   lspc_strobe_edge u_data_edge (
      .clk    (CLK_24M),
      .reset  (RESET),
      .strobe (WR_VRAM_RW),
      .fire   (data_fire)
   );

   always_ff @(posedge CLK_24M) begin
      if (!RESET) begin
         state        <= ST_IDLE;
         wr_pend      <= 1'b0;
         rd_pend      <= 1'b0;
         latch        <= '0;
         REG_VRAMADDR <= AW'(VRAM_RESET_ADDR);
         REG_VRAMRW   <= '0;
         VRAM_ADDR    <= AW'(VRAM_RESET_ADDR);
         VRAM_WDATA   <= '0;
         nVRAM_WE     <= 1'b1;
         VRAM_CPU_SEL <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (CPU_SLOT && wr_pend) begin
                  state        <= ST_WR_ACC;
                  VRAM_ADDR    <= REG_VRAMADDR;
                  VRAM_WDATA   <= latch;
                  nVRAM_WE     <= 1'b0;
                  VRAM_CPU_SEL <= 1'b1;
               end else if (CPU_SLOT && rd_pend) begin
                  state        <= ST_RD_ACC;
                  VRAM_ADDR    <= REG_VRAMADDR;
                  nVRAM_WE     <= 1'b1;
                  VRAM_CPU_SEL <= 1'b1;
               end
            end
            ST_WR_ACC: begin
               state        <= ST_IDLE;
               nVRAM_WE     <= 1'b1;
               VRAM_CPU_SEL <= 1'b0;
               REG_VRAMADDR <= REG_VRAMADDR + AW'(REG_VRAMMOD);
               wr_pend      <= 1'b0;
               rd_pend      <= 1'b1;
            end
            ST_RD_ACC: begin
               state <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               state        <= ST_IDLE;
               VRAM_CPU_SEL <= 1'b0;
               REG_VRAMRW   <= VRAM_RDATA;
               rd_pend      <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
         // Strobe events override the FSM's flag and pointer updates.
         if (addr_fire) begin
            REG_VRAMADDR <= AW'(M68K_DATA);
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b1;
         end
         if (data_fire) begin
            latch   <= DW'(M68K_DATA);
            wr_pend <= 1'b1;
         end
      end
   end

   assign nVRAM_WRITE_REQ = ~wr_pend;
   assign BUSY            = wr_pend | rd_pend | (state != ST_IDLE);

endmodule

// File: tb/tb_lspc_vram_access.sv
// Self-checking bench for lspc_vram_access: directed cases plus random traffic.
module tb_lspc_vram_access;

   logic        clk = 1'b0;
   logic        RESET;
   logic        WR_VRAM_ADDR;
   logic        WR_VRAM_RW;
   logic [15:0] M68K_DATA;
   logic [15:0] REG_VRAMMOD;
   logic        CPU_SLOT;
   logic [15:0] VRAM_RDATA;
   logic [15:0] VRAM_ADDR;
   logic [15:0] VRAM_WDATA;
   logic        nVRAM_WE;
   logic        VRAM_CPU_SEL;
   logic [15:0] REG_VRAMADDR;
   logic [15:0] REG_VRAMRW;
   logic        nVRAM_WRITE_REQ;
   logic        BUSY;

   always #5 clk = ~clk;

   lspc_vram_access #(.AW(16), .DW(16)) dut (
      .CLK_24M         (clk),
      .RESET           (RESET),
      .WR_VRAM_ADDR    (WR_VRAM_ADDR),
      .WR_VRAM_RW      (WR_VRAM_RW),
      .M68K_DATA       (M68K_DATA),
      .REG_VRAMMOD     (REG_VRAMMOD),
      .CPU_SLOT        (CPU_SLOT),
      .VRAM_RDATA      (VRAM_RDATA),
      .VRAM_ADDR       (VRAM_ADDR),
      .VRAM_WDATA      (VRAM_WDATA),
      .nVRAM_WE        (nVRAM_WE),
      .VRAM_CPU_SEL    (VRAM_CPU_SEL),
      .REG_VRAMADDR    (REG_VRAMADDR),
      .REG_VRAMRW      (REG_VRAMRW),
      .nVRAM_WRITE_REQ (nVRAM_WRITE_REQ),
      .BUSY            (BUSY)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Bench VRAM: written words, otherwise a fixed hash of the address.
   logic [15:0] wmem [logic [15:0]];

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      logic [15:0] h;
      if (wmem.exists(a)) return wmem[a];
      h = a * 16'h9E37;
      return h ^ 16'h5A5A;
   endfunction

   // Reference model: access phase 0 idle, 1 write, 2 read addr, 3 capture.
   int          m_ph;
   logic [15:0] m_ptr, m_latch, m_addr, m_wdata, m_rw;
   logic        m_wp, m_rp, m_we, m_sel, a_prev, d_prev;

   task automatic m_reset();
      m_ph = 0; m_ptr = 0; m_latch = 0; m_addr = 0; m_wdata = 0;
      m_rw = 0; m_wp = 0; m_rp = 0; m_we = 1; m_sel = 0;
      a_prev = 1; d_prev = 1;
   endtask

   task automatic m_step();
      logic a_ev, d_ev;
      a_ev = !WR_VRAM_ADDR && a_prev;
      d_ev = !WR_VRAM_RW && d_prev;
      if (!RESET) begin
         m_reset();
         return;
      end
      a_prev = WR_VRAM_ADDR;
      d_prev = WR_VRAM_RW;
      case (m_ph)
         0: if (CPU_SLOT) begin
            if (m_wp) begin
               m_ph = 1; m_addr = m_ptr; m_wdata = m_latch;
               m_we = 0; m_sel = 1;
               wmem[m_ptr] = m_latch;
            end else if (m_rp) begin
               m_ph = 2; m_addr = m_ptr; m_we = 1; m_sel = 1;
            end
         end
         1: begin
            m_ph = 0; m_we = 1; m_sel = 0;
            m_ptr = m_ptr + REG_VRAMMOD;
            m_wp = 0; m_rp = 1;
         end
         2: m_ph = 3;
         default: begin
            m_ph = 0; m_sel = 0; m_rw = mem_rd(m_addr); m_rp = 0;
         end
      endcase
      if (a_ev) begin
         m_ptr = M68K_DATA; m_wp = 0; m_rp = 1;
      end
      if (d_ev) begin
         m_latch = M68K_DATA; m_wp = 1;
      end
   endtask

   task automatic compare_all();
      chk("ptr",   REG_VRAMADDR,    m_ptr);
      chk("rw",    REG_VRAMRW,      m_rw);
      chk("vaddr", VRAM_ADDR,       m_addr);
      chk("wdata", VRAM_WDATA,      m_wdata);
      chk("we_n",  nVRAM_WE,        m_we);
      chk("sel",   VRAM_CPU_SEL,    m_sel);
      chk("wreq",  nVRAM_WRITE_REQ, !m_wp);
      chk("busy",  BUSY,            m_wp | m_rp | (m_ph != 0));
   endtask

   // One clock: check at negedge, drive inputs for the next rising edge.
   task automatic cyc(input logic r, input logic wa, input logic wrw,
                      input logic [15:0] d, input logic sl);
      compare_all();
      VRAM_RDATA   = mem_rd(VRAM_ADDR);
      RESET        = r;
      WR_VRAM_ADDR = wa;
      WR_VRAM_RW   = wrw;
      M68K_DATA    = d;
      CPU_SLOT     = sl;
      m_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 1, 1, 16'h0000, 0);
   endtask

   task automatic wr_addr(input logic [15:0] v);
      cyc(1, 0, 1, v, 0);
      cyc(1, 1, 1, 16'h0000, 0);
   endtask

   task automatic wr_data(input logic [15:0] v);
      cyc(1, 1, 0, v, 0);
      cyc(1, 1, 1, 16'h0000, 0);
   endtask

   task automatic slot();
      cyc(1, 1, 1, 16'h0000, 1);
   endtask

   initial begin
      RESET = 0; WR_VRAM_ADDR = 1; WR_VRAM_RW = 1;
      M68K_DATA = 0; REG_VRAMMOD = 16'h0001; CPU_SLOT = 0; VRAM_RDATA = 0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_we",   nVRAM_WE, 1'b1);
      chk("rst_busy", BUSY, 1'b0);

      // Address then read
      wmem[16'h7000] = 16'hBEEF;
      wr_addr(16'h7000);
      slot();
      chk("rd_addr", VRAM_ADDR, 16'h7000);
      chk("rd_sel",  VRAM_CPU_SEL, 1'b1);
      idle(2);
      chk("rd_data", REG_VRAMRW, 16'hBEEF);
      idle(1);

      // Write with modulo, then prefetch
      REG_VRAMMOD = 16'h0020;
      wr_addr(16'h1000);
      wr_data(16'h1234);
      slot();
      chk("wr_we",    nVRAM_WE, 1'b0);
      chk("wr_addr",  VRAM_ADDR, 16'h1000);
      chk("wr_data",  VRAM_WDATA, 16'h1234);
      idle(1);
      chk("mod_ptr",  REG_VRAMADDR, 16'h1020);
      slot();
      chk("pf_addr",  VRAM_ADDR, 16'h1020);
      idle(3);

      // Wrap-around
      wr_addr(16'hFFF0);
      wr_data(16'hABCD);
      slot();
      idle(1);
      chk("wrap_ptr", REG_VRAMADDR, 16'h0010);
      slot();
      idle(3);

      // Cancel
      wr_data(16'h5555);
      wr_addr(16'h2000);
      chk("cancel_req", nVRAM_WRITE_REQ, 1'b1);
      slot();
      chk("cancel_we",   nVRAM_WE, 1'b1);
      chk("cancel_addr", VRAM_ADDR, 16'h2000);
      idle(3);

      // Overwrite before slot
      wr_data(16'h1111);
      wr_data(16'h2222);
      slot();
      chk("ovr_data", VRAM_WDATA, 16'h2222);
      chk("ovr_we",   nVRAM_WE, 1'b0);
      idle(1);
      chk("ovr_one",  nVRAM_WRITE_REQ, 1'b1);
      slot();
      idle(3);

      // Address event during WR_ACC
      wr_addr(16'h3000);
      wr_data(16'h4444);
      slot();
      cyc(1, 0, 1, 16'h5000, 0);
      chk("coll_ptr",  REG_VRAMADDR, 16'h5000);
      chk("coll_wreq", nVRAM_WRITE_REQ, 1'b1);
      chk("coll_busy", BUSY, 1'b1);
      idle(1);
      slot();
      idle(3);

      // Reset held three cycles mid-write
      wr_data(16'h6666);
      slot();
      chk("pre_rst_we", nVRAM_WE, 1'b0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'h0000, 0);
      chk("rst2_we",   nVRAM_WE, 1'b1);
      chk("rst2_ptr",  REG_VRAMADDR, 16'h0000);
      chk("rst2_busy", BUSY, 1'b0);
      idle(2);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 63) == 0)
            REG_VRAMMOD = 16'($urandom);
         cyc($urandom_range(0, 199) != 0,
             $urandom_range(0, 5) != 0,
             $urandom_range(0, 4) != 0,
             16'($urandom),
             $urandom_range(0, 2) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lspc_vram_access.md
# lspc_vram_access

CPU-side VRAM access sequencer for the LSPC. It owns the REG_VRAMADDR pointer and the pending-write and pending-read flags, and runs CPU writes and read prefetches only in the CPU access slots granted by the video timing generator. After each write it post-increments the address by REG_VRAMMOD. It sits between the LSPC register decoder and the VRAM address/data multiplexers.

## Interface
Parameters:
- `AW`, 16: VRAM address width.
- `DW`, 16: VRAM data width.

Ports:
- `CLK_24M` in 1: master clock. All state changes on the rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `WR_VRAM_ADDR` in 1: active-low decoder strobe for the REG_VRAMADDR write. Level input, can stay low for several clocks.
- `WR_VRAM_RW` in 1: active-low decoder strobe for the REG_VRAMRW write.
- `M68K_DATA` in 16: CPU write data.
- `REG_VRAMMOD` in 16: address modulo.
- `CPU_SLOT` in 1: one-cycle advance grant from video timing. The access runs in the following cycle.
- `VRAM_RDATA` in 16: VRAM read data, valid one cycle after the address is presented.
- `VRAM_ADDR` out 16: CPU-side VRAM address.
- `VRAM_WDATA` out 16: write data.
- `nVRAM_WE` out 1: active-low write enable.
- `VRAM_CPU_SEL` out 1: steers the VRAM muxes to the CPU side.
- `REG_VRAMADDR` out 16: current address pointer.
- `REG_VRAMRW` out 16: read latch, which the CPU sees on reads.
- `nVRAM_WRITE_REQ` out 1: low while a write is pending.
- `BUSY` out 1: high while any access is pending or in flight.

## Operation
- **Strobe detection.** Each strobe is sampled into a register. A strobe "event" is a cycle where the strobe is low and its previous sample was high. `M68K_DATA` is captured in that event cycle.
- **Address event:**
  - REG_VRAMADDR loads the captured data.
  - WR_PEND clears, which cancels any unissued write.
  - RD_PEND sets.
- **Data event:**
  - The data latch loads.
  - WR_PEND sets.
  - A second data event before issue overwrites the latch, and only one write is performed (latest data wins).
- **States:**
  - IDLE: waits for `CPU_SLOT`.
  - WR_ACC: write access cycle.
  - RD_ACC: address-presentation cycle of a read.
  - RD_CAP: read data capture cycle.
- **IDLE transitions** (only on `CPU_SLOT`=1):
  - WR_PEND set: go to WR_ACC. Write takes priority over read.
  - Otherwise RD_PEND set: go to RD_ACC.
  - Otherwise stay in IDLE, and the slot is unused.
- **WR_ACC** (one cycle):
  - Outputs: `VRAM_CPU_SEL`=1, `nVRAM_WE`=0, `VRAM_ADDR`=REG_VRAMADDR, `VRAM_WDATA`=the latch value frozen at grant.
  - On exit: REG_VRAMADDR += REG_VRAMMOD (16-bit, wraps modulo 2^16), WR_PEND clears, RD_PEND sets, next state IDLE.
- **RD_ACC:** `VRAM_CPU_SEL`=1, `nVRAM_WE`=1, `VRAM_ADDR`=REG_VRAMADDR. Next state RD_CAP.
- **RD_CAP:** REG_VRAMRW loads `VRAM_RDATA`, RD_PEND clears, next state IDLE.
- **Outputs and reset values:**
  - `nVRAM_WRITE_REQ` = ~WR_PEND.
  - `BUSY` = WR_PEND | RD_PEND | (state != IDLE).
  - Reset values: `VRAM_ADDR`, `VRAM_WDATA`, `REG_VRAMADDR`, `REG_VRAMRW` = 0x0000; `nVRAM_WE`=1; `VRAM_CPU_SEL`=0; `nVRAM_WRITE_REQ`=1; `BUSY`=0; state IDLE; both strobe history registers = 1.

## Timing
- **Event to flag:** a strobe event at edge n makes WR_PEND / RD_PEND visible after edge n.
- **Write latency:** `CPU_SLOT` high in cycle s gives WR_ACC in cycle s+1, and the incremented address is visible from cycle s+2.
- **Read latency:** `CPU_SLOT` high in cycle s gives RD_ACC in s+1, RD_CAP in s+2, and REG_VRAMRW updated from s+3.
- **`CPU_SLOT` outside IDLE** is ignored. No queueing.
- **Address event during WR_ACC:**
  - The in-flight write completes at the old address.
  - The post-increment is suppressed; the new address wins.
  - WR_PEND ends cleared and RD_PEND set.
- **Data event during WR_ACC:** the latch and WR_PEND are updated. The in-flight `VRAM_WDATA` is unaffected, and a second write follows at the next slot.
- **Address event during RD_ACC/RD_CAP:** the capture still completes, but RD_PEND remains set, so the read is re-issued at the new address.
- **Simultaneous address and data events:** the address load applies, then the data write stays pending (WR_PEND=1, RD_PEND=1).
- **Reset low in any state:** all registers return to their reset values at that edge. An in-flight write is terminated (`nVRAM_WE`=1 next cycle).

## Structure
- Shared package `lspc_pkg`:
  - State enum: ST_IDLE, ST_WR_ACC, ST_RD_ACC, ST_RD_CAP.
  - Constant VRAM_RESET_ADDR = 16'h0000.
- One sub-module, `lspc_strobe_edge`: an active-low strobe falling-edge detector with synchronous reset, instantiated twice.
- The top-level block holds the FSM, the pointer/latch registers and the adder.

## Test plan
- **Reset:** hold `RESET`=0 for 3 cycles mid-WR_ACC -> all outputs at reset values, `nVRAM_WE`=1 the next cycle.
- **Address then read:**
  - Stimulus: address event with 0x7000, VRAM returns 0xBEEF, `CPU_SLOT` pulse.
  - Response: `VRAM_ADDR`=0x7000 in RD_ACC; REG_VRAMRW=0xBEEF three cycles after the slot.
- **Write with modulo:**
  - Stimulus: REG_VRAMMOD=0x0020, address 0x1000, data 0x1234, two slots.
  - Response: write of 0x1234 to 0x1000, pointer becomes 0x1020, prefetch read at 0x1020.
- **Wrap-around:** address 0xFFF0, modulo 0x0020, one write -> pointer 0x0010.
- **Cancel:** data event, then address event 0x2000 before any slot -> no `nVRAM_WE` pulse, `nVRAM_WRITE_REQ`=1, read at 0x2000.
- **Overwrite and collision:**
  - Two data events (0x1111, then 0x2222) before a slot -> a single write of 0x2222.
  - Address event during WR_ACC -> pointer equals the new value, not incremented.
